// File: rtl/reg_wr_arbiter.sv
// reg_wr_arbiter
// -----------------------------------------------------------------------------
// Shares the register-file write port between two writeback requesters:
// port 0 (ALU writeback) and port 1 (memory/load writeback). Each port has a
// one-entry holding slot with a valid/ready handshake. Slots are granted
// oldest-first, so writes reach the register file in transfer order. A
// per-register pending-write scoreboard (o_busy) is exported for decode.
//
// Ports:
//   i_clk          clock, all state updates on the rising edge
//   i_rst_n        synchronous active-low reset
//   i_req0_valid   ALU write request valid
//   i_req0_dest    ALU destination register
//   i_req0_data    ALU write data
//   o_req0_ready   ALU slot can accept
//   i_req1_valid   MEM write request valid
//   i_req1_dest    MEM destination register
//   i_req1_data    MEM write data
//   o_req1_ready   MEM slot can accept
//   o_reg_wr_en    register-file write enable (registered)
//   o_reg_wr_dest  register-file write address (registered)
//   o_reg_wr_data  register-file write data (registered)
//   o_busy         bit d high while a write to register d is pending
//   o_wr_count     number of writes issued on o_reg_wr_en (wraps)
// -----------------------------------------------------------------------------
module reg_wr_arbiter #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,

    input  logic                       i_req0_valid,
    input  logic [ADDR_W-1:0]          i_req0_dest,
    input  logic [DATA_W-1:0]          i_req0_data,
    output logic                       o_req0_ready,

    input  logic                       i_req1_valid,
    input  logic [ADDR_W-1:0]          i_req1_dest,
    input  logic [DATA_W-1:0]          i_req1_data,
    output logic                       o_req1_ready,

    output logic                       o_reg_wr_en,
    output logic [ADDR_W-1:0]          o_reg_wr_dest,
    output logic [DATA_W-1:0]          o_reg_wr_data,

    output logic [(1 << ADDR_W)-1:0]   o_busy,
    output logic [CNT_W-1:0]           o_wr_count
);

    localparam int unsigned NUM_REGS = 1 << ADDR_W;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic              r_slot0_valid;
    logic [ADDR_W-1:0] r_slot0_dest;
    logic [DATA_W-1:0] r_slot0_data;

    logic              r_slot1_valid;
    logic [ADDR_W-1:0] r_slot1_dest;
    logic [DATA_W-1:0] r_slot1_data;

    // High when slot 1 holds the older entry. Only meaningful while both
    // slots are valid.
    logic              r_slot1_older;

    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_dest;
    logic [DATA_W-1:0] r_wr_data;
    logic [CNT_W-1:0]  r_wr_count;

    // -------------------------------------------------------------------------
    // Arbitration and handshake
    // -------------------------------------------------------------------------
    logic              w_grant0;
    logic              w_grant1;
    logic              w_xfer0;
    logic              w_xfer1;
    logic              w_slot0_valid_nxt;
    logic              w_slot1_valid_nxt;
    logic              w_slot1_older_nxt;
    logic              w_any_grant;
    logic [ADDR_W-1:0] w_gnt_dest;
    logic [DATA_W-1:0] w_gnt_data;
    logic              w_wr_en_nxt;

    always_comb begin
        w_grant0 = r_slot0_valid && (!r_slot1_valid || !r_slot1_older);
        w_grant1 = r_slot1_valid && (!r_slot0_valid ||  r_slot1_older);
    end

    // A granted slot drains this cycle, so it may reload on the same edge.
    // Readies are held low while reset is asserted so nothing is accepted
    // on the reset edge.
    assign o_req0_ready = i_rst_n && (!r_slot0_valid || w_grant0);
    assign o_req1_ready = i_rst_n && (!r_slot1_valid || w_grant1);

    assign w_xfer0 = i_req0_valid && o_req0_ready;
    assign w_xfer1 = i_req1_valid && o_req1_ready;

    always_comb begin
        w_slot0_valid_nxt = r_slot0_valid;
        if (w_xfer0) begin
            w_slot0_valid_nxt = 1'b1;
        end else if (w_grant0) begin
            w_slot0_valid_nxt = 1'b0;
        end

        w_slot1_valid_nxt = r_slot1_valid;
        if (w_xfer1) begin
            w_slot1_valid_nxt = 1'b1;
        end else if (w_grant1) begin
            w_slot1_valid_nxt = 1'b0;
        end
    end

    // The slot loaded on this edge becomes the younger one whenever the
    // other slot stays occupied. Same-edge loads leave slot 0 older.
    always_comb begin
        w_slot1_older_nxt = r_slot1_older;
        if (w_xfer0 && w_xfer1) begin
            w_slot1_older_nxt = 1'b0;
        end else if (w_xfer0 && w_slot1_valid_nxt) begin
            w_slot1_older_nxt = 1'b1;
        end else if (w_xfer1 && w_slot0_valid_nxt) begin
            w_slot1_older_nxt = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Output stage
    // -------------------------------------------------------------------------
    always_comb begin
        w_any_grant = w_grant0 || w_grant1;
        w_gnt_dest  = w_grant1 ? r_slot1_dest : r_slot0_dest;
        w_gnt_data  = w_grant1 ? r_slot1_data : r_slot0_data;
        // Writes to register 0 drain through the arbiter but never strobe
        // the register file.
        w_wr_en_nxt = w_any_grant && (w_gnt_dest != '0);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_slot0_valid <= 1'b0;
            r_slot0_dest  <= '0;
            r_slot0_data  <= '0;
            r_slot1_valid <= 1'b0;
            r_slot1_dest  <= '0;
            r_slot1_data  <= '0;
            r_slot1_older <= 1'b0;
            r_wr_en       <= 1'b0;
            r_wr_dest     <= '0;
            r_wr_data     <= '0;
            r_wr_count    <= '0;
        end else begin
            r_slot0_valid <= w_slot0_valid_nxt;
            r_slot1_valid <= w_slot1_valid_nxt;
            r_slot1_older <= w_slot1_older_nxt;

            if (w_xfer0) begin
                r_slot0_dest <= i_req0_dest;
                r_slot0_data <= i_req0_data;
            end
            if (w_xfer1) begin
                r_slot1_dest <= i_req1_dest;
                r_slot1_data <= i_req1_data;
            end

            r_wr_en <= w_wr_en_nxt;
            // Address and data hold their last value on idle cycles.
            if (w_any_grant) begin
                r_wr_dest <= w_gnt_dest;
                r_wr_data <= w_gnt_data;
            end
            if (w_wr_en_nxt) begin
                r_wr_count <= r_wr_count + CNT_W'(1);
            end
        end
    end

    assign o_reg_wr_en   = r_wr_en;
    assign o_reg_wr_dest = r_wr_dest;
    assign o_reg_wr_data = r_wr_data;
    assign o_wr_count    = r_wr_count;

    // -------------------------------------------------------------------------
    // Pending-write scoreboard, from registered state only
    // -------------------------------------------------------------------------
    logic [NUM_REGS-1:0] w_busy;

    always_comb begin
        w_busy = '0;
        for (int unsigned d = 1; d < NUM_REGS; d++) begin
            if ((r_slot0_valid && (r_slot0_dest == ADDR_W'(d))) ||
                (r_slot1_valid && (r_slot1_dest == ADDR_W'(d))) ||
                (r_wr_en       && (r_wr_dest    == ADDR_W'(d)))) begin
                w_busy[d] = 1'b1;
            end
        end
    end

    assign o_busy = w_busy;

endmodule
